// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding for the scan chain controller
package scan_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SHIFT_IN  = 2'd1;
    localparam logic [1:0] ST_CAPTURE   = 2'd2;
    localparam logic [1:0] ST_SHIFT_OUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        SHIFT_IN  = ST_SHIFT_IN,
        CAPTURE   = ST_CAPTURE,
        SHIFT_OUT = ST_SHIFT_OUT
    } scan_state_t;

endpackage

// File: rtl/scan_chain_seg.sv
// rtl/scan_chain_seg.sv - one WIDTH-bit scan chain with shift and parallel capture
module scan_chain_seg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             cap,
    input  logic             sd,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Shift wins over capture; the controller never asserts both together.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sd};
        end else if (cap) begin
            q <= d;
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - multi-chain scan register with shift-in/capture/shift-out sequencer
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCHAINS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       func_en,
    input  logic                       start,
    input  logic [NCHAINS-1:0]         sd,
    input  logic [NCHAINS*WIDTH-1:0]   d,
    output logic [NCHAINS*WIDTH-1:0]   q,
    output logic [NCHAINS-1:0]         so,
    output logic                       se,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             shift;
    logic             cap;

    // In IDLE an accepted start freezes the chains for that edge, even with func_en high.
    assign shift = (state == SHIFT_IN) || (state == SHIFT_OUT);
    assign cap   = (state == CAPTURE) || ((state == IDLE) && !start && func_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            se    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT_IN;
                        cnt   <= '0;
                        se    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SHIFT_IN: begin
                    if (cnt == CNT_LAST) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                        se    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    state <= SHIFT_OUT;
                    cnt   <= '0;
                    se    <= 1'b1;
                end
                SHIFT_OUT: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        se  <= 1'b0;
                        if (start) begin
                            state <= CAPTURE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        done <= (cnt == CNT_PENULT);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    se    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NCHAINS; c++) begin : g_chain
        scan_chain_seg #(.WIDTH(WIDTH)) u_seg (
            .clk   (clk),
            .reset (reset),
            .shift (shift),
            .cap   (cap),
            .sd    (sd[c]),
            .d     (d[c*WIDTH +: WIDTH]),
            .q     (q[c*WIDTH +: WIDTH])
        );
        assign so[c] = q[c*WIDTH + WIDTH - 1];
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - self-checking bench for scan_chain_ctrl (WIDTH=8, NCHAINS=2)
module tb_scan_chain_ctrl;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        func_en = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  sd = '0;
    logic [15:0] d = '0;
    logic [15:0] q;
    logic [1:0]  so;
    logic        se;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Reference model: step counts position in the pattern timeline.
    // 0 idle, 1..W shift-in, W+1 capture, W+2..2W+1 shift-out.
    int       mstep = 0;
    bit [7:0] mch [2];

    typedef struct {
        bit          rst;
        bit          fen;
        bit          st;
        logic [1:0]  sdv;
        logic [15:0] dv;
        logic [15:0] eq;
        bit          ese;
        bit          ebusy;
        bit          edone;
    } vec_t;

    vec_t tbl [4];

    scan_chain_ctrl #(.WIDTH(W), .NCHAINS(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .func_en (func_en),
        .start   (start),
        .sd      (sd),
        .d       (d),
        .q       (q),
        .so      (so),
        .se      (se),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit f, input bit s,
                              input logic [1:0] sdv, input logic [15:0] dv);
        if (r) begin
            mstep = 0;
            mch[0] = '0;
            mch[1] = '0;
        end else if (mstep == 0) begin
            if (s) mstep = 1;
            else if (f) begin
                mch[0] = dv[7:0];
                mch[1] = dv[15:8];
            end
        end else if (mstep == W + 1) begin
            mch[0] = dv[7:0];
            mch[1] = dv[15:8];
            mstep++;
        end else begin
            for (int c = 0; c < 2; c++) mch[c] = {mch[c][6:0], sdv[c]};
            if (mstep == 2 * W + 1) mstep = s ? W + 1 : 0;
            else mstep++;
        end
    endtask

    task automatic model_check();
        bit ese;
        bit ebusy;
        bit edone;
        ebusy = (mstep != 0);
        ese   = (mstep >= 1 && mstep <= W) || (mstep >= W + 2);
        edone = (mstep == 2 * W + 1);
        chk("model_q", q, {mch[1], mch[0]});
        chk("model_so_se_busy_done", {11'd0, so, se, busy, done},
            {11'd0, mch[1][7], mch[0][7], ese, ebusy, edone});
    endtask

    task automatic tick(input bit r, input bit f, input bit s,
                        input logic [1:0] sdv, input logic [15:0] dv);
        reset = r;
        func_en = f;
        start = s;
        sd = sdv;
        d = dv;
        model_step(r, f, s, sdv, dv);
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        bit [7:0]  p0;
        bit [7:0]  p1;
        bit [7:0]  so0;
        bit [7:0]  so1;
        int        se_cnt;
        int        cyc;
        int        done_cyc;
        int        first_done;
        int        done_cnt;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 2'b00, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 2'b11, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 2'b11, 16'hFFFF, 16'h1234, 1'b1, 1'b1, 1'b0};

        // Table vectors: reset, functional capture/hold, start beating func_en.
        for (int i = 0; i < 4; i++) begin
            tick(tbl[i].rst, tbl[i].fen, tbl[i].st, tbl[i].sdv, tbl[i].dv);
            chk($sformatf("tbl%0d_q", i), q, tbl[i].eq);
            chk($sformatf("tbl%0d_flags", i), {13'd0, se, busy, done},
                {13'd0, tbl[i].ese, tbl[i].ebusy, tbl[i].edone});
        end

        // Shift in 0xA5 / 0x3C, first bit ends at the MSB.
        p0 = 8'hA5;
        p1 = 8'h3C;
        se_cnt = int'(se);
        cyc = 1;
        done_cyc = -1;
        for (int i = 0; i < W; i++) begin
            tick(1'b0, 1'b0, 1'b0, {p1[7-i], p0[7-i]}, 16'h5AC3);
            se_cnt += int'(se);
            cyc++;
        end
        chk("shift_in_q", q, 16'h3CA5);
        chk("se_cycles", 16'(se_cnt), 16'd8);
        chk("capture_state_busy", {15'd0, busy}, 16'd1);

        tick(1'b0, 1'b0, 1'b0, 2'b00, 16'h5AC3);
        cyc++;
        chk("capture_q", q, 16'h5AC3);

        // Shift out while loading the next pattern; keep start high for overlap.
        p0 = 8'h96;
        p1 = 8'h4E;
        for (int i = 0; i < W; i++) begin
            so0[7-i] = so[0];
            so1[7-i] = so[1];
            if (done && done_cyc < 0) done_cyc = cyc;
            chk($sformatf("done_pos%0d", i), {15'd0, done}, {15'd0, (i == W - 1)});
            tick(1'b0, 1'b0, 1'b1, {p1[7-i], p0[7-i]}, 16'h1357);
            cyc++;
        end
        chk("so0_stream", {8'd0, so0}, 16'h00C3);
        chk("so1_stream", {8'd0, so1}, 16'h005A);
        chk("done_latency", 16'(done_cyc), 16'd17);
        chk("overlap_loaded", q, 16'h4E96);
        chk("overlap_capture_se_busy", {14'd0, se, busy}, 16'b01);

        tick(1'b0, 1'b0, 1'b0, 2'b00, 16'h1357);
        cyc++;
        chk("overlap_capture_q", q, 16'h1357);

        // Second pattern: stray start mid shift-out must be ignored.
        for (int i = 0; i < W; i++) begin
            if (done) done_cnt = cyc;
            tick(1'b0, 1'b0, (i == 3), 2'b10, 16'h0000);
            cyc++;
        end
        chk("done_spacing", 16'(done_cnt - done_cyc), 16'd9);
        chk("idle_after_done", {14'd0, busy, se}, 16'd0);

        // Reset in the middle of shift-in aborts with no done pulse.
        tick(1'b0, 1'b0, 1'b1, 2'b11, 16'h0000);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 2'b11, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000);
        chk("reset_mid_q", q, 16'h0000);
        chk("reset_mid_flags", {13'd0, se, busy, done}, 16'd0);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 1'b0, 2'b11, 16'hAAAA);
            done_cnt += int'(done);
        end
        chk("reset_no_done", 16'(done_cnt), 16'd0);

        // Randomised run against the model.
        first_done = 0;
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, 2'($urandom), 16'($urandom));
            first_done += int'(done);
        end
        checks++;
        if (first_done == 0) begin
            errors++;
            $display("FAIL random_done_seen: got %0d done pulses expected >0", first_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Parametrised multi-chain scan register with a built-in test-sequencing FSM.
- Generalises a hand-wired chain of scan flops: shift chain Q[i] <= Q[i-1], Q[0] <= SD.
- Adds three features:
  - NCHAINS parallel chains of WIDTH flops each.
  - Automatic shift-in / capture / shift-out sequencing with a cycle counter.
  - Overlapped load/unload for back-to-back patterns.
- Sits between the test bench or tester and the functional logic whose state it observes and controls.

Parameters:
- WIDTH, 8, flops per chain (>=2).
- NCHAINS, 2, number of independent parallel chains.
- CNT_W, $clog2(WIDTH), shift counter width (derived; not to be overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- func_en  in  1  in IDLE, functional capture every cycle (q <= d).
- start  in  1  begin a scan pattern (sampled in IDLE, and on the last SHIFT_OUT cycle).
- sd  in  NCHAINS  serial scan-in, one bit per chain.
- d  in  NCHAINS*WIDTH  functional data; chain c occupies bits [c*WIDTH +: WIDTH].
- q  out  NCHAINS*WIDTH  flop outputs, same packing as d.
- so  out  NCHAINS  serial scan-out; so[c] = q[c*WIDTH+WIDTH-1], combinational from q.
- se  out  1  high while in SHIFT_IN or SHIFT_OUT (registered with state).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the last SHIFT_OUT cycle.

Behaviour:
- Reset (synchronous): state=IDLE, cnt=0, q=0, se=0, busy=0, done=0.
  - Reset applied mid-sequence aborts the sequence: chain contents are lost and done is not pulsed.
- Shift operation, per chain c, each shift cycle:
  - q[c*WIDTH] <= sd[c].
  - q[c*WIDTH+i] <= q[c*WIDTH+i-1] for i = 1..WIDTH-1.
  - Consequence: the first bit shifted in ends at the MSB of the chain after WIDTH shifts.
- FSM states: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT.
- IDLE:
  - start=1 -> SHIFT_IN, cnt=0; q holds this cycle. start has priority over func_en.
  - Otherwise, func_en=1 -> q <= d.
  - Otherwise q holds.
- SHIFT_IN:
  - Shift every cycle; cnt increments.
  - When cnt==WIDTH-1, move to CAPTURE after that shift (exactly WIDTH shifts), cnt <= 0.
- CAPTURE:
  - Exactly one cycle: q <= d, then -> SHIFT_OUT. se=0 in this cycle.
- SHIFT_OUT:
  - Shift every cycle; so presents captured bits MSB first; sd loads the next pattern concurrently.
  - On cnt==WIDTH-1: done=1 for that cycle, cnt <= 0, then:
    - start=1 -> CAPTURE directly (overlapped mode; the pattern just shifted in is applied).
    - start=0 -> IDLE.
- start outside IDLE and the last SHIFT_OUT cycle is ignored.
- func_en is ignored outside IDLE.
- Latency, one pattern: WIDTH + 1 + WIDTH cycles from the start-accept edge to done.
  - Back-to-back patterns: WIDTH+1 cycles per pattern.
- Counter wraps only via explicit clear. It never exceeds WIDTH-1; this holds for non-power-of-2 WIDTH.
- All chains share the FSM and counter and always shift in lockstep.

Decomposition:
- Shared package scan_pkg:
  - State enum type (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT).
  - Localparam encodings.
- Sub-module scan_chain_seg, one per chain via generate. It holds the WIDTH-bit register with inputs:
  - shift
  - cap
  - sd
  - d
- Top level holds the FSM, counter and output decode only.

Test Plan (WIDTH=8, NCHAINS=2):
- Reset mid-SHIFT_IN (cycle 4) -> next cycle state IDLE, q=0x0000, busy=0, no done pulse.
- IDLE, func_en=1, d=0x1234, start=0 -> next cycle q=0x1234, busy=0, se=0.
  - Then func_en=0, d=0xFFFF -> q stays 0x1234.
- start with sd[0] bits 1,0,1,0,0,1,0,1 and sd[1] bits 0,0,1,1,1,1,0,0 -> after 8 shifts chain0=0xA5, chain1=0x3C, q=0x3CA5; se=1 for exactly 8 cycles.
- CAPTURE with d=0x5AC3 -> q=0x5AC3.
  - During SHIFT_OUT, so[0] emits 1,1,0,0,0,0,1,1 and so[1] emits 0,1,0,1,1,0,1,0.
  - done high only on the 8th SHIFT_OUT cycle, 17 cycles after start accepted.
- start held high continuously with a new pattern on sd -> after done, the FSM enters CAPTURE directly.
  - The second done arrives 9 cycles after the first.
  - The captured value equals d, not the shifted-in pattern.
- start and func_en both high in IDLE -> SHIFT_IN entered, q unchanged (not d) on that edge.
  - start pulsed mid-SHIFT_OUT -> ignored, FSM returns to IDLE after done.
